// File: rtl/frame_loader_pkg.sv
// frame_loader_pkg: shared LED-chain defaults and byte-packing FSM encodings
package frame_loader_pkg;
  localparam int d_ledboards = 30;
  localparam int ch_per_board = 32;
  localparam int d_bpc = 12;
  localparam logic [1:0] s_b0 = 2'd0;
  localparam logic [1:0] s_b1 = 2'd1;
  localparam logic [1:0] s_b2 = 2'd2;
endpackage

// File: rtl/frame_loader_dpram.sv
// dpram_2bank: two-bank channel store, one write port and one registered read port
module dpram_2bank import frame_loader_pkg::*; #(
  parameter int aw = 10,
  parameter int dw = d_bpc
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [aw:0]   wa,
  input  logic [dw-1:0] wd,
  input  logic [aw:0]   ra,
  output logic [dw-1:0] rd
);
  logic [dw-1:0] mem [2**(aw+1)];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // only the read register is reset; the array itself keeps whatever it held
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd <= '0;
    else rd <= mem[ra];
endmodule

// File: rtl/frame_loader.sv
// frame_loader: unpacks a 12-bit-per-channel byte stream into a double-buffered frame store
module frame_loader import frame_loader_pkg::*; #(
  parameter int c_ledboards = d_ledboards,
  parameter int c_channels = c_ledboards * ch_per_board,
  parameter int c_addr_w = $clog2(c_channels),
  parameter int c_bpc = d_bpc
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [7:0]          i_byte,
  input  logic                i_valid,
  input  logic                i_sof,
  output logic                o_ready,
  input  logic [c_addr_w-1:0] i_rd_addr,
  output logic [c_bpc-1:0]    o_rd_data,
  input  logic                i_lat,
  output logic                o_swap,
  output logic                o_err
);
  logic [1:0] state;
  logic [c_addr_w-1:0] waddr;
  logic [7:0] b0;
  logic [3:0] b1_lo;
  logic pending, sel, lat_q, rdy;
  logic acc, sof_err, we, last, swap;
  logic [c_bpc-1:0] wd;
  assign o_ready = rdy & ~pending;
  assign acc = i_valid & o_ready;
  assign sof_err = acc & i_sof & (state != s_b0 || waddr != '0);
  assign we = acc & ~sof_err & (state != s_b0);
  assign wd = (state == s_b1) ? {b0, i_byte[7:4]} : {b1_lo, i_byte};
  assign last = (state == s_b2) && (waddr == c_addr_w'(c_channels - 1));
  // pending is only set on a clock edge, so a latch edge coinciding with the last byte is ignored
  assign swap = pending & i_lat & ~lat_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= s_b0;
      waddr <= '0;
      b0 <= '0;
      b1_lo <= '0;
      pending <= 1'b0;
      sel <= 1'b0;
      lat_q <= 1'b0;
      rdy <= 1'b0;
      o_swap <= 1'b0;
      o_err <= 1'b0;
    end else begin
      rdy <= 1'b1;
      lat_q <= i_lat;
      o_err <= sof_err;
      o_swap <= swap;
      if (swap) begin
        sel <= ~sel;
        pending <= 1'b0;
      end
      if (acc) begin
        if (sof_err || state == s_b0) begin
          b0 <= i_byte;
          state <= s_b1;
          if (sof_err) waddr <= '0;
        end else if (state == s_b1) begin
          b1_lo <= i_byte[3:0];
          state <= s_b2;
          waddr <= waddr + 1'b1;
        end else begin
          state <= s_b0;
          waddr <= last ? '0 : waddr + 1'b1;
          if (last) pending <= 1'b1;
        end
      end
    end
  // sel names the back bank; the driver reads the other one
  dpram_2bank #(.aw(c_addr_w), .dw(c_bpc)) u_mem (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .we(we),
    .wa({sel, waddr}),
    .wd(wd),
    .ra({~sel, i_rd_addr}),
    .rd(o_rd_data)
  );
endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: directed and table-driven checks of frame unpacking, swapping and framing errors
module tb_frame_loader;
  import frame_loader_pkg::*;
  localparam int nch = d_ledboards * ch_per_board;
  localparam int aw = $clog2(nch);
  localparam int nb = nch * 3 / 2;
  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [11:0] c0, c1;
  } vec_t;
  vec_t vt[3];
  logic i_clk = 0, i_rst_n = 0, i_valid = 0, i_sof = 0, i_lat = 0;
  logic [7:0] i_byte = '0;
  logic [aw-1:0] i_rd_addr = '0;
  logic o_ready, o_swap, o_err;
  logic [11:0] o_rd_data;
  int checks = 0, errors = 0;
  logic [7:0] fr [3][nb];

  frame_loader dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_byte(i_byte), .i_valid(i_valid),
    .i_sof(i_sof), .o_ready(o_ready), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .i_lat(i_lat), .o_swap(o_swap), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic sof, input int gap);
    int n = 0;
    i_valid = 0;
    repeat (gap) tick();
    i_byte = b;
    i_sof = sof;
    i_valid = 1;
    while (!o_ready && n < 200) begin
      tick();
      n++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: o_ready stayed 0 for %0d cycles, expected 1", n);
    end
    tick();
    i_valid = 0;
    i_sof = 0;
  endtask

  task automatic send_pat(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int from, input int to);
    for (int i = from; i < to; i++)
      send((i % 3 == 0) ? b0 : (i % 3 == 1) ? b1 : b2, i == 0, 0);
  endtask

  task automatic rd(input int a, output logic [11:0] d);
    i_rd_addr = aw'(a);
    tick();
    d = o_rd_data;
  endtask

  task automatic lat(output logic sw);
    i_lat = 1;
    tick();
    i_lat = 0;
    sw = o_swap;
  endtask

  task automatic send_frame(input int f);
    for (int i = 0; i < nb; i++) send(fr[f][i], i == 0, $urandom_range(0, 2));
  endtask

  task automatic check_frame(input int f);
    int mism = 0;
    logic [11:0] d, e;
    for (int c = 0; c < nch; c++) begin
      rd(c, d);
      e = (c % 2 == 0) ? {fr[f][3*(c/2)], fr[f][3*(c/2)+1][7:4]}
                       : {fr[f][3*(c/2)+1][3:0], fr[f][3*(c/2)+2]};
      if (d !== e) mism++;
    end
    chk($sformatf("bp_frame%0d_mismatches", f), mism, 0);
  endtask

  initial begin
    logic sw;
    logic [11:0] d;
    vt[0] = '{8'hAB, 8'hCD, 8'hEF, 12'hABC, 12'hDEF};
    vt[1] = '{8'h12, 8'h34, 8'h56, 12'h123, 12'h456};
    vt[2] = '{8'hF0, 8'h0F, 8'hA5, 12'hF00, 12'hFA5};
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < nb; i++) fr[f][i] = 8'($urandom_range(0, 255));

    tick();
    tick();
    chk("rst_ready", o_ready, 0);
    chk("rst_swap", o_swap, 0);
    chk("rst_err", o_err, 0);
    chk("rst_rd_data", o_rd_data, 0);
    i_rst_n = 1;
    chk("ready_before_first_clk", o_ready, 0);
    tick();
    chk("ready_after_rst", o_ready, 1);

    for (int k = 0; k < 3; k++) begin
      send_pat(vt[k].b0, vt[k].b1, vt[k].b2, 0, nb - 1);
      chk("ready_before_last", o_ready, 1);
      send(vt[k].b2, 0, 0);
      chk("ready_after_last", o_ready, 0);
      chk("err_quiet", o_err, 0);
      tick();
      tick();
      chk("ready_held_low", o_ready, 0);
      chk("no_swap_before_lat", o_swap, 0);
      lat(sw);
      chk("swap_pulse", sw, 1);
      tick();
      chk("swap_one_cycle", o_swap, 0);
      chk("ready_after_swap", o_ready, 1);
      rd(0, d);
      chk("ch0", d, vt[k].c0);
      rd(1, d);
      chk("ch1", d, vt[k].c1);
      rd(nch - 2, d);
      chk("ch_last_even", d, vt[k].c0);
      rd(nch - 1, d);
      chk("ch_last", d, vt[k].c1);
    end

    lat(sw);
    chk("idle_lat_no_swap_a", sw, 0);
    tick();
    lat(sw);
    chk("idle_lat_no_swap_b", sw, 0);
    rd(0, d);
    chk("idle_front_ch0", d, 12'hF00);
    rd(1, d);
    chk("idle_front_ch1", d, 12'hFA5);

    send(8'hAB, 1, 0);
    chk("sof_at_start_no_err", o_err, 0);
    send(8'hCD, 1, 0);
    chk("sof_in_b1_err", o_err, 1);
    send(8'hEF, 0, 0);
    chk("err_one_cycle", o_err, 0);
    send(8'h77, 0, 0);
    send(8'h12, 1, 0);
    chk("sof_at_addr2_err", o_err, 1);
    send_pat(8'h12, 8'h34, 8'h56, 1, nb);
    chk("err_frame_ready_low", o_ready, 0);
    lat(sw);
    chk("err_frame_swap", sw, 1);
    tick();
    rd(0, d);
    chk("err_frame_ch0", d, 12'h123);
    rd(1, d);
    chk("err_frame_ch1", d, 12'h456);
    rd(nch - 1, d);
    chk("err_frame_ch_last", d, 12'h456);

    send_pat(8'h99, 8'h88, 8'h77, 0, 700);
    i_rst_n = 0;
    #1;
    chk("midrst_ready", o_ready, 0);
    chk("midrst_swap", o_swap, 0);
    chk("midrst_err", o_err, 0);
    chk("midrst_rd_data", o_rd_data, 0);
    tick();
    i_rst_n = 1;
    tick();
    chk("midrst_ready_back", o_ready, 1);
    send_pat(8'h3C, 8'h5A, 8'h78, 0, nb - 1);
    i_lat = 1;
    send(8'h78, 0, 0);
    chk("lat_with_last_byte_no_swap", o_swap, 0);
    i_lat = 0;
    tick();
    chk("lat_deferred_no_swap", o_swap, 0);
    lat(sw);
    chk("deferred_swap", sw, 1);
    tick();
    rd(0, d);
    chk("midrst_ch0", d, 12'h3C5);
    rd(1, d);
    chk("midrst_ch1", d, 12'hA78);

    send_frame(0);
    for (int f = 0; f < 3; f++) begin
      fork
        begin
          if (f < 2) send_frame(f + 1);
        end
        begin
          repeat (10) tick();
          lat(sw);
          chk($sformatf("bp_swap%0d", f), sw, 1);
          tick();
          check_frame(f);
        end
      join
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 SHALL have parameter c_ledboards, default 30, meaning number of chained LED boards.
REQ-002 SHALL have parameter c_channels, default c_ledboards*32, meaning channels per frame (even).
REQ-003 SHALL have parameter c_addr_w, default $clog2(c_channels), meaning channel address width.
REQ-004 SHALL have parameter c_bpc, default 12, meaning bits per channel (fixed 12 for the packing rules below).
REQ-005 SHALL have port i_clk, input, 1, sole clock for all logic.
REQ-006 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_byte, input, 8, incoming pixel byte.
REQ-008 SHALL have port i_valid, input, 1, i_byte valid.
REQ-009 SHALL have port i_sof, input, 1, marks the qualified byte as first byte of a frame.
REQ-010 SHALL have port o_ready, output, 1, byte accepted when i_valid & o_ready.
REQ-011 SHALL have port i_rd_addr, input, c_addr_w, channel read address from the LED driver.
REQ-012 SHALL have port o_rd_data, output, c_bpc, channel value for i_rd_addr.
REQ-013 SHALL have port i_lat, input, 1, latch strobe from the LED driver (frame boundary).
REQ-014 SHALL have port o_swap, output, 1, one-cycle pulse when the front buffer changes.
REQ-015 SHALL have port o_err, output, 1, one-cycle pulse on a framing error.

Function
REQ-016 SHALL hold two frame banks of c_channels x 12 bits; the driver reads the front bank, the byte stream writes the back bank.
REQ-017 SHALL unpack 3 accepted bytes b0,b1,b2 into channels n and n+1: ch[n]={b0,b1[7:4]}, ch[n+1]={b1[3:0],b2}.
REQ-018 SHALL use a packing FSM with states s_b0, s_b1, s_b2; each accepted byte advances s_b0->s_b1->s_b2->s_b0.
REQ-019 SHALL write ch[n] to the back bank on acceptance of b1, and ch[n+1] on acceptance of b2.
REQ-020 SHALL increment the write address by 1 per channel written, starting at 0.
REQ-021 SHALL set a pending flag and return FSM to s_b0 when channel c_channels-1 is written (1.5*c_channels bytes per frame, 1440 at default).
REQ-022 SHALL drive o_ready low while pending is set, and high otherwise outside reset.
REQ-023 SHALL, on the first cycle where pending is set and i_lat rises (i_lat high, previous-cycle i_lat low), toggle the front/back bank select, clear pending, and pulse o_swap.
REQ-024 SHALL ignore i_lat rising edges while pending is clear; front bank is re-displayed unchanged.
REQ-025 SHALL, when pending is set and an i_lat rising edge arrive on the same cycle, defer the swap to the next i_lat rising edge.
REQ-026 SHALL, on an accepted byte with i_sof high while FSM not in s_b0 or write address not 0, pulse o_err, discard the partial frame, reset write address to 0, and treat that byte as b0.
REQ-027 SHALL treat an accepted i_sof byte at FSM s_b0 and write address 0 as a normal b0 with no error.
REQ-028 SHALL register o_rd_data with exactly 1 cycle latency from i_rd_addr, reading the front bank.
REQ-029 SHALL make a bank swap visible on o_rd_data for reads issued in the cycle after o_swap.

Reset
REQ-030 SHALL, with i_rst_n low, asynchronously force: FSM s_b0, write address 0, pending 0, bank select 0 (back=0, front=1), o_ready 0, o_swap 0, o_err 0, o_rd_data 0, previous-i_lat register 0.
REQ-031 SHALL drive o_ready high on the first clock after i_rst_n deasserts.
REQ-032 SHALL leave bank memory contents unreset; front-bank contents are undefined until the first swap.
REQ-033 SHALL, on reset mid-frame, abandon the partial frame completely.

Structure
REQ-034 SHALL place the defaults for c_ledboards, c_bpc, channels-per-board (32), and the FSM state encodings in a shared package used by frame_loader and the LED driver.
REQ-035 SHALL implement storage as a sub-module dpram_2bank: 1 write port, 1 registered read port, address {bank, channel}.

Verification
REQ-036 SHALL cover: after reset, stream 1440 bytes with the pattern 0xAB,0xCD,0xEF repeated -> ch[0]=0xABC and ch[1]=0xDEF in the back bank; o_ready drops after byte 1440.
REQ-037 SHALL cover: full frame followed by an i_lat pulse -> o_swap pulses 1 cycle later; read addr 0 -> o_rd_data=0xABC next cycle; o_ready high again.
REQ-038 SHALL cover: i_lat pulses with no complete frame -> no o_swap and front data unchanged.
REQ-039 SHALL cover: i_sof on byte 2 of 3 -> o_err pulse; then a complete 1440-byte frame of 0x12,0x34,0x56 -> ch[0]=0x123, ch[1]=0x456.
REQ-040 SHALL cover: i_rst_n low after 700 bytes -> all outputs at reset values; a subsequent full frame and i_lat swap correctly.
REQ-041 SHALL cover: i_valid toggling randomly with back-pressure -> no bytes lost or duplicated across 3 frames.
